// File: rtl/ls_queue_pkg.sv
// Shared definitions for the load/store queue: ROB tag width, opcodes,
// access-length codes and the memory FSM state encoding.
package ls_queue_pkg;

  localparam int ROB_WIDTH = 4;

  // bit3 = store, bit2 = unsigned load, bits[1:0] = access length
  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LH  = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LBU = 4'b0100;
  localparam logic [3:0] OP_LHU = 4'b0101;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_STORE_WAIT = 3'd2,
    ST_STORE      = 3'd3,
    ST_DONE       = 3'd4
  } state_e;

  function automatic logic op_is_store(input logic [3:0] op);
    return op[3];
  endfunction

endpackage

// File: rtl/ls_extend.sv
// Load-data extension: sign-extends LB/LH, zero-extends LBU/LHU, passes LW raw.
module ls_extend
  import ls_queue_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] data
);

  // Select extension by opcode; unknown codes pass the raw word through
  always_comb begin
    data = raw;
    case (op)
      OP_LB:   data = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   data = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  data = {24'd0, raw[7:0]};
      OP_LHU:  data = {16'd0, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue. Entries wait for operands (snooping the result
// buses), then the head entry runs one memory transaction at a time.
// Handshake: mem_re/mem_we are held with stable address/data until the cycle
// mem_done is sampled high (with rdy_in), and drop in that same update;
// out_valid is a single-cycle pulse with no back-pressure.
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int ROB_W = ROB_WIDTH,
  parameter int NCDB  = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  clear,
  output logic                  full,
  input  logic                  iss_valid,
  input  logic [3:0]            iss_op,
  input  logic [31:0]           iss_vj,
  input  logic [31:0]           iss_vk,
  input  logic                  iss_dj,
  input  logic                  iss_dk,
  input  logic [ROB_W-1:0]      iss_qj,
  input  logic [ROB_W-1:0]      iss_qk,
  input  logic [ROB_W-1:0]      iss_rob,
  input  logic [31:0]           iss_imm,
  input  logic [NCDB-1:0]       cdb_valid,
  input  logic [NCDB*ROB_W-1:0] cdb_tag,
  input  logic [NCDB*32-1:0]    cdb_val,
  input  logic                  commit_valid,
  input  logic [ROB_W-1:0]      commit_tag,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [1:0]            mem_len,
  input  logic                  mem_done,
  input  logic [31:0]           mem_rdata,
  output logic                  out_valid,
  output logic [ROB_W-1:0]      out_tag,
  output logic [31:0]           out_val,
  output state_e                dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DEPTH-1:0] busy_q, busy_d, dj_q, dj_d, dk_q, dk_d;
  logic [3:0]       op_q  [DEPTH];
  logic [3:0]       op_d  [DEPTH];
  logic [31:0]      vj_q  [DEPTH];
  logic [31:0]      vj_d  [DEPTH];
  logic [31:0]      vk_q  [DEPTH];
  logic [31:0]      vk_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      imm_d [DEPTH];
  logic [ROB_W-1:0] qj_q  [DEPTH];
  logic [ROB_W-1:0] qj_d  [DEPTH];
  logic [ROB_W-1:0] qk_q  [DEPTH];
  logic [ROB_W-1:0] qk_d  [DEPTH];
  logic [ROB_W-1:0] rob_q [DEPTH];
  logic [ROB_W-1:0] rob_d [DEPTH];

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  state_e        state_q, state_d;

  logic             full_q, full_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]       mem_len_q, mem_len_d;
  logic             out_valid_q, out_valid_d;
  logic [ROB_W-1:0] out_tag_q, out_tag_d;
  logic [31:0]      out_val_q, out_val_d;

  logic [AW-1:0] hidx, tidx;
  logic          h_ready, keep_head;
  logic [31:0]   h_addr, h_ext;
  logic [31:0]   iss_vj_c, iss_vk_c;
  logic          iss_dj_c, iss_dk_c;

  assign hidx    = head_q[AW-1:0];
  assign tidx    = tail_q[AW-1:0];
  assign h_ready = busy_q[hidx] && !dj_q[hidx] && !dk_q[hidx];
  assign h_addr  = vk_q[hidx] + imm_q[hidx];

  ls_extend u_ext (
    .op   (op_q[hidx]),
    .raw  (mem_rdata),
    .data (h_ext)
  );

  // Capture operands broadcast in the issue cycle; lowest channel wins
  always_comb begin
    iss_vj_c = iss_vj;
    iss_dj_c = iss_dj;
    iss_vk_c = iss_vk;
    iss_dk_c = iss_dk;
    for (int k = NCDB - 1; k >= 0; k--) begin
      if (iss_dj && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == iss_qj) begin
        iss_vj_c = cdb_val[k*32 +: 32];
        iss_dj_c = 1'b0;
      end
      if (iss_dk && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == iss_qk) begin
        iss_vk_c = cdb_val[k*32 +: 32];
        iss_dk_c = 1'b0;
      end
    end
  end

  // Next-state: snoop, head FSM, issue, then flush (flush has the last word)
  always_comb begin
    busy_d = busy_q;  dj_d = dj_q;  dk_d = dk_q;
    op_d = op_q;  vj_d = vj_q;  vk_d = vk_q;  imm_d = imm_q;
    qj_d = qj_q;  qk_d = qk_q;  rob_d = rob_q;
    head_d = head_q;  tail_d = tail_q;  state_d = state_q;
    mem_re_d = mem_re_q;  mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;  mem_wdata_d = mem_wdata_q;  mem_len_d = mem_len_q;
    out_valid_d = out_valid_q;  out_tag_d = out_tag_q;  out_val_d = out_val_q;
    keep_head = 1'b0;

    if (rdy_in) begin
      out_valid_d = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        for (int k = NCDB - 1; k >= 0; k--) begin
          if (busy_q[i] && dj_q[i] && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == qj_q[i]) begin
            vj_d[i] = cdb_val[k*32 +: 32];
            dj_d[i] = 1'b0;
          end
          if (busy_q[i] && dk_q[i] && cdb_valid[k] && cdb_tag[k*ROB_W +: ROB_W] == qk_q[i]) begin
            vk_d[i] = cdb_val[k*32 +: 32];
            dk_d[i] = 1'b0;
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (h_ready) begin
            mem_addr_d = h_addr;
            mem_len_d  = op_q[hidx][1:0];
            if (op_is_store(op_q[hidx])) begin
              state_d     = ST_STORE_WAIT;
              out_valid_d = 1'b1;
              out_tag_d   = rob_q[hidx];
              out_val_d   = 32'd0;
            end else begin
              state_d  = ST_LOAD;
              mem_re_d = 1'b1;
            end
          end
        end
        ST_STORE_WAIT: begin
          if (commit_valid && commit_tag == rob_q[hidx]) begin
            state_d     = ST_STORE;
            mem_we_d    = 1'b1;
            mem_wdata_d = vj_q[hidx];
            mem_addr_d  = h_addr;
            mem_len_d   = op_q[hidx][1:0];
          end
        end
        ST_LOAD: begin
          if (mem_done) begin
            state_d      = ST_DONE;
            mem_re_d     = 1'b0;
            out_valid_d  = 1'b1;
            out_tag_d    = rob_q[hidx];
            out_val_d    = h_ext;
            busy_d[hidx] = 1'b0;
            head_d       = head_q + PW'(1);
          end
        end
        ST_STORE: begin
          if (mem_done) begin
            state_d      = ST_IDLE;
            mem_we_d     = 1'b0;
            busy_d[hidx] = 1'b0;
            head_d       = head_q + PW'(1);
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      if (iss_valid && !full_q) begin
        busy_d[tidx] = 1'b1;
        op_d[tidx]   = iss_op;
        vj_d[tidx]   = iss_vj_c;
        vk_d[tidx]   = iss_vk_c;
        dj_d[tidx]   = iss_dj_c;
        dk_d[tidx]   = iss_dk_c;
        qj_d[tidx]   = iss_qj;
        qk_d[tidx]   = iss_qk;
        rob_d[tidx]  = iss_rob;
        imm_d[tidx]  = iss_imm;
        tail_d       = tail_q + PW'(1);
      end

      if (clear) begin
        if (state_q == ST_STORE) begin
          // The committed store in flight must complete; everything else goes
          keep_head    = busy_d[hidx];
          busy_d       = '0;
          busy_d[hidx] = keep_head;
          tail_d       = head_q + PW'(1);
        end else begin
          busy_d      = '0;
          head_d      = '0;
          tail_d      = '0;
          state_d     = ST_IDLE;
          mem_re_d    = 1'b0;
          mem_we_d    = 1'b0;
          out_valid_d = 1'b0;
        end
      end
    end

    full_d = (head_d[AW-1:0] == tail_d[AW-1:0]) && (head_d[AW] != tail_d[AW]);
  end

  // Register all queue, FSM and output state
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      busy_q      <= '0;
      dj_q        <= '0;
      dk_q        <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      full_q      <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_len_q   <= '0;
      out_valid_q <= 1'b0;
      out_tag_q   <= '0;
      out_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      dj_q        <= dj_d;
      dk_q        <= dk_d;
      op_q        <= op_d;
      vj_q        <= vj_d;
      vk_q        <= vk_d;
      imm_q       <= imm_d;
      qj_q        <= qj_d;
      qk_q        <= qk_d;
      rob_q       <= rob_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      full_q      <= full_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_len_q   <= mem_len_d;
      out_valid_q <= out_valid_d;
      out_tag_q   <= out_tag_d;
      out_val_q   <= out_val_d;
    end
  end

  assign full      = full_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_len   = mem_len_q;
  assign out_valid = out_valid_q;
  assign out_tag   = out_tag_q;
  assign out_val   = out_val_q;
  assign dbg_state = state_q;

endmodule

// File: doc/ls_queue.md
LS_QUEUE -- requirements
Module: ls_queue

Interface
REQ-001 The block SHALL take parameter DEPTH, default 8, as the entry count (a power of two, >=4).
REQ-002 The block SHALL take parameter ROB_W, default `ROB_WIDTH, as the ROB tag width.
REQ-003 The block SHALL take parameter NCDB, default 2, as the number of result-broadcast snoop channels.
REQ-004 The block SHALL have these ports; clock and reset: clk_in in 1, system clock; rst_in in 1, synchronous active-high reset; rdy_in in 1, global stall when low.
REQ-005 The block SHALL have these flush and issue ports: clear in 1, pipeline flush; full out 1, no free entry; iss_valid in 1, decoder issue; iss_op in 4, LB/LH/LW/LBU/LHU/SB/SH/SW encoding, bit3 = store; iss_vj in 32, store data; iss_vk in 32, base address; iss_dj and iss_dk in 1 each, operand pending; iss_qj and iss_qk in ROB_W each, producer tags; iss_rob in ROB_W, own tag; iss_imm in 32, offset.
REQ-006 The block SHALL have these snoop and commit ports: cdb_valid in NCDB, snoop valids; cdb_tag in NCDB*ROB_W, snoop tags; cdb_val in NCDB*32, snoop values; commit_valid in 1, ROB retiring a store; commit_tag in ROB_W, tag of that store.
REQ-007 The block SHALL have these memory ports: mem_re out 1, read request; mem_we out 1, write request; mem_addr out 32, byte address; mem_wdata out 32, write data; mem_len out 2, 0=byte, 1=half, 2=word; mem_done in 1, transaction complete; mem_rdata in 32, raw read data.
REQ-008 The block SHALL have these broadcast ports: out_valid out 1, result broadcast; out_tag out ROB_W, tag; out_val out 32, value.

Function
REQ-009 Entries SHALL form a circular FIFO with head/tail pointers of log2(DEPTH) bits plus one wrap bit; full = (DEPTH entries occupied); empty = pointers equal.
REQ-010 When iss_valid && !full, the block SHALL write the tail entry and advance tail; iss_valid while full SHALL be ignored.
REQ-011 At issue, an operand whose tag matches any same-cycle valid cdb channel SHALL be captured as ready, with that value, immediately.
REQ-012 Each cycle, every busy entry with pending operand tag == cdb_tag[k] && cdb_valid[k] SHALL capture cdb_val[k]; if several channels match, the lowest k SHALL win.
REQ-013 Memory access SHALL be strictly in program order from head only; one transaction SHALL be outstanding at most.
REQ-014 The FSM SHALL have states IDLE, LOAD, STORE_WAIT, STORE, DONE.
REQ-015 IDLE->LOAD: head busy, is a load, both operands ready; mem_re=1, mem_addr=vk+imm (mod 2^32), mem_len from op[1:0].
REQ-016 IDLE->STORE_WAIT: head busy, is a store, both operands ready; out_valid pulses 1 cycle with the store tag and out_val=0, so the ROB can retire it.
REQ-017 STORE_WAIT->STORE: commit_valid && commit_tag == head tag; mem_we=1, mem_wdata=vj, mem_addr=vk+imm.
REQ-018 mem_re/mem_we SHALL remain asserted, with stable address/data, until mem_done; on mem_done they SHALL drop in that same registered update.
REQ-019 LOAD->DONE on mem_done: out_valid=1 for exactly one cycle; out_val = sign-extended byte/half for LB/LH, zero-extended for LBU/LHU, raw for LW; entry freed, head advances.
REQ-020 STORE->IDLE on mem_done: entry freed, head advances; no broadcast.
REQ-021 DONE->IDLE unconditionally, giving one dead cycle between loads.
REQ-022 Issue and head retire in the same cycle SHALL both take effect; full SHALL be correct afterwards.
REQ-023 While rdy_in=0, all state and outputs SHALL hold, with mem_done ignored.
REQ-024 clear (with rdy_in) SHALL empty the queue and return to IDLE, except in state STORE, where only that entry survives: FSM stays in STORE, then goes IDLE on mem_done with an empty queue.
REQ-025 clear in LOAD SHALL drop mem_re next cycle and suppress the broadcast.

Reset
REQ-026 With rst_in=1 at clk_in rising edge, the FSM SHALL enter IDLE, all entries become free, pointers become 0, and all outputs become 0 (full=0); rst_in overrides rdy_in and any in-flight transaction.

Structure
REQ-027 Opcode encodings, mem_len codes and FSM state encoding SHALL live in the shared package/header alongside ROB_WIDTH.
REQ-028 A single sub-module ls_extend (combinational load-data sign/zero extension by op) SHALL be instantiated.

Verification
REQ-029 Test load issue: LW vk=0x100, imm=4, no deps -> mem_re with addr 0x104, len 2; mem_done with rdata 0xDEADBEEF -> out_valid 1 cycle, out_val 0xDEADBEEF.
REQ-030 Test load extension: LB with rdata 0x80 -> out_val 0xFFFFFF80; LBU with rdata 0x80 -> out_val 0x00000080.
REQ-031 Test store commit: SW with dj pending tag 5; cdb channel 1 broadcasts tag 5, value 7 -> out_valid with store tag; commit -> mem_we with wdata 7; mem_done -> head advances.
REQ-032 Test full/wrap: issue DEPTH loads -> full=1 and the next iss_valid is ignored; drain 3 loads and issue 3 more across the wrap -> results in program order.
REQ-033 Test clear during STORE: mem_we stays asserted until mem_done; queue is empty afterwards.
REQ-034 Test clear during LOAD: mem_re drops and no out_valid appears.
